// File: rtl/decode_stage_pkg.sv
// Shared RV base-opcode constants, immediate-type encodings and the
// per-instruction classification helper used by decode_stage.
package decode_stage_pkg;

  localparam logic [6:0] RISCV_LUI      = 7'b0110111;
  localparam logic [6:0] RISCV_AUIPC    = 7'b0010111;
  localparam logic [6:0] RISCV_JAL      = 7'b1101111;
  localparam logic [6:0] RISCV_JALR     = 7'b1100111;
  localparam logic [6:0] RISCV_BRANCH   = 7'b1100011;
  localparam logic [6:0] RISCV_LOAD     = 7'b0000011;
  localparam logic [6:0] RISCV_STORE    = 7'b0100011;
  localparam logic [6:0] RISCV_OP_IMM   = 7'b0010011;
  localparam logic [6:0] RISCV_OP       = 7'b0110011;
  localparam logic [6:0] RISCV_MISC_MEM = 7'b0001111;
  localparam logic [6:0] RISCV_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  typedef struct packed {
    logic rs1_used;
    logic rs2_used;
    logic rd_write;
    logic illegal;
  } dec_flags_t;

  // Opcode outside the base set (including instr[1:0] != 2'b11) is illegal
  // and reports no register use.
  function automatic dec_flags_t classify(input logic [31:0] instr);
    dec_flags_t f;
    logic       wr;
    f  = '0;
    wr = 1'b0;
    case (instr[6:0])
      RISCV_OP: begin
        f.rs1_used = 1'b1;
        f.rs2_used = 1'b1;
        wr         = 1'b1;
      end
      RISCV_OP_IMM, RISCV_LOAD, RISCV_JALR: begin
        f.rs1_used = 1'b1;
        wr         = 1'b1;
      end
      RISCV_STORE, RISCV_BRANCH: begin
        f.rs1_used = 1'b1;
        f.rs2_used = 1'b1;
      end
      RISCV_LUI, RISCV_AUIPC, RISCV_JAL: wr = 1'b1;
      RISCV_MISC_MEM, RISCV_SYSTEM: ;
      default: f.illegal = 1'b1;
    endcase
    f.rd_write = wr & (instr[11:7] != 5'd0);
    return f;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: builds the format-specific immediate
// and sign-extends bit 31 to XLEN (U-type included).
module decode_imm_gen
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output logic            o_imm_valid,
  output imm_type_e       o_imm_type
);

  logic [31:0] w_imm32;

  always_comb begin
    w_imm32    = '0;
    o_imm_type = IMM_NONE;
    case (i_instr[6:0])
      RISCV_JALR, RISCV_LOAD, RISCV_OP_IMM: begin
        o_imm_type = IMM_I;
        w_imm32    = {{20{i_instr[31]}}, i_instr[31:20]};
      end
      RISCV_STORE: begin
        o_imm_type = IMM_S;
        w_imm32    = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      end
      RISCV_BRANCH: begin
        o_imm_type = IMM_B;
        w_imm32    = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};
      end
      RISCV_LUI, RISCV_AUIPC: begin
        o_imm_type = IMM_U;
        w_imm32    = {i_instr[31:12], 12'h000};
      end
      RISCV_JAL: begin
        o_imm_type = IMM_J;
        w_imm32    = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                      i_instr[20], i_instr[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  assign o_imm_valid = (o_imm_type != IMM_NONE);
  // Replicating XLEN-31 copies keeps the expression legal when XLEN == 32.
  assign o_imm       = {{(XLEN-31){w_imm32[31]}}, w_imm32[30:0]};

endmodule

// File: rtl/decode_stage.sv
// Registered RV32/RV64 decode stage with valid/ready on both sides.
// Optional DECODE_SKID_EN: registered in_ready plus a 1-entry skid buffer.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [6:0]          out_opcode,
  output logic [2:0]          out_func3,
  output logic [6:0]          out_func7,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [4:0]          out_rd,
  output logic [XLEN-1:0]     out_imm,
  output logic                out_imm_valid,
  output logic [2:0]          out_imm_type,
  output logic                out_rs1_used,
  output logic                out_rs2_used,
  output logic                out_rd_write,
  output logic                out_illegal
);

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         instr;
    logic [XLEN-1:0]     imm;
    logic                imm_valid;
    logic [2:0]          imm_type;
    dec_flags_t          flags;
  } stage_t;

  logic [XLEN-1:0] w_imm;
  logic            w_imm_valid;
  imm_type_e       w_imm_type;
  stage_t          w_dec;
  stage_t          r_out;
  logic            r_out_valid;
  logic            w_in_fire;

  decode_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr     (in_instr),
    .o_imm       (w_imm),
    .o_imm_valid (w_imm_valid),
    .o_imm_type  (w_imm_type)
  );

  always_comb begin
    w_dec           = '0;
    w_dec.pc        = in_pc;
    w_dec.instr     = in_instr;
    w_dec.imm       = w_imm;
    w_dec.imm_valid = w_imm_valid;
    w_dec.imm_type  = w_imm_type;
    w_dec.flags     = classify(in_instr);
  end

  assign w_in_fire = in_valid & in_ready;

`ifdef DECODE_SKID_EN
  stage_t r_skid;
  logic   r_skid_valid;
  logic   r_in_ready;
  logic   w_out_load;

  assign in_ready   = r_in_ready;
  assign w_out_load = !r_out_valid | out_ready;

  // in_ready is only low while the skid holds an entry, so an input never
  // arrives in the same cycle the skid drains into the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (w_out_load) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else if (w_in_fire) begin
        r_out       <= w_dec;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
      r_in_ready   <= 1'b0;
    end
  end
`else
  assign in_ready = !r_out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_out       <= w_dec;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

  assign out_valid     = r_out_valid;
  assign out_pc        = r_out.pc;
  assign out_opcode    = r_out.instr[6:0];
  assign out_func3     = r_out.instr[14:12];
  assign out_func7     = r_out.instr[31:25];
  assign out_rs1       = r_out.instr[19:15];
  assign out_rs2       = r_out.instr[24:20];
  assign out_rd        = r_out.instr[11:7];
  assign out_imm       = r_out.imm;
  assign out_imm_valid = r_out.imm_valid;
  assign out_imm_type  = r_out.imm_type;
  assign out_rs1_used  = r_out.flags.rs1_used;
  assign out_rs2_used  = r_out.flags.rs2_used;
  assign out_rd_write  = r_out.flags.rd_write;
  assign out_illegal   = r_out.flags.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: XLEN=32 and XLEN=64 instances share
// stimulus; expected decodes come from an independent reference model.
module tb_decode_stage;

`ifdef DECODE_SKID_EN
  localparam int EXP_STALL_ACC = 1;
`else
  localparam int EXP_STALL_ACC = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        a_in_ready, a_out_valid, a_imm_valid, a_rs1u, a_rs2u, a_rdw, a_ill;
  logic [31:0] a_pc, a_imm;
  logic [6:0]  a_op, a_f7;
  logic [2:0]  a_f3, a_it;
  logic [4:0]  a_rs1, a_rs2, a_rd;

  logic        b_in_ready, b_out_valid, b_imm_valid, b_rs1u, b_rs2u, b_rdw, b_ill;
  logic [31:0] b_pc;
  logic [63:0] b_imm;
  logic [6:0]  b_op, b_f7;
  logic [2:0]  b_f3, b_it;
  logic [4:0]  b_rs1, b_rs2, b_rd;

  decode_stage #(.XLEN(32), .PC_WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_opcode(a_op), .out_func3(a_f3), .out_func7(a_f7),
    .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd), .out_imm(a_imm),
    .out_imm_valid(a_imm_valid), .out_imm_type(a_it), .out_rs1_used(a_rs1u),
    .out_rs2_used(a_rs2u), .out_rd_write(a_rdw), .out_illegal(a_ill));

  decode_stage #(.XLEN(64), .PC_WIDTH(32)) u_dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_opcode(b_op), .out_func3(b_f3), .out_func7(b_f7),
    .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd), .out_imm(b_imm),
    .out_imm_valid(b_imm_valid), .out_imm_type(b_it), .out_rs1_used(b_rs1u),
    .out_rs2_used(b_rs2u), .out_rd_write(b_rdw), .out_illegal(b_ill));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
    logic        iv;
    logic [2:0]  it;
    logic        r1, r2, wr, il;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  logic [104:0] obs32;
  logic [136:0] obs64;
  assign obs32 = {a_out_valid, a_pc, a_f7, a_rs2, a_rs1, a_f3, a_rd, a_op, a_imm,
                  a_imm_valid, a_it, a_rs1u, a_rs2u, a_rdw, a_ill};
  assign obs64 = {b_out_valid, b_pc, b_f7, b_rs2, b_rs1, b_f3, b_rd, b_op, b_imm,
                  b_imm_valid, b_it, b_rs1u, b_rs2u, b_rdw, b_ill};

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    logic wr;
    e = '0; e.pc = pc; e.instr = i; wr = 1'b0;
    case (i[6:0])
      7'b0110111, 7'b0010111: begin e.it = 3'd4; e.imm = {i[31:12], 12'h000}; wr = 1'b1; end
      7'b1101111: begin
        e.it = 3'd5; wr = 1'b1;
        e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      end
      7'b1100111, 7'b0000011, 7'b0010011: begin
        e.it = 3'd1; e.imm = {{20{i[31]}}, i[31:20]}; e.r1 = 1'b1; wr = 1'b1;
      end
      7'b0100011: begin
        e.it = 3'd2; e.imm = {{20{i[31]}}, i[31:25], i[11:7]}; e.r1 = 1'b1; e.r2 = 1'b1;
      end
      7'b1100011: begin
        e.it = 3'd3; e.r1 = 1'b1; e.r2 = 1'b1;
        e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      end
      7'b0110011: begin e.r1 = 1'b1; e.r2 = 1'b1; wr = 1'b1; end
      7'b0001111, 7'b1110011: ;
      default: e.il = 1'b1;
    endcase
    e.iv = (e.it != 3'd0);
    e.wr = wr && (i[11:7] != 5'd0);
    return e;
  endfunction

  function automatic logic [104:0] sig32(input exp_t e);
    return {1'b1, e.pc, e.instr, e.imm, e.iv, e.it, e.r1, e.r2, e.wr, e.il};
  endfunction

  function automatic logic [136:0] sig64(input exp_t e);
    return {1'b1, e.pc, e.instr, {{32{e.imm[31]}}, e.imm}, e.iv, e.it, e.r1, e.r2, e.wr, e.il};
  endfunction

  function automatic logic [31:0] rand_instr(input int k);
    logic [6:0]  ops [12];
    logic [31:0] r;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
            7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011, 7'b0101011};
    r = $urandom();
    return {r[31:7], ops[k % 12]};
  endfunction

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_instr = 32'hFFF10093; in_pc = 32'h40;
    repeat (3) @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); else n_pass++;
    n_total++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1)
      $display("FAIL reset_in_ready got=%b/%b exp=1/1", a_in_ready, b_in_ready); else n_pass++;
    n_total++; if (obs32 !== '0) $display("FAIL reset_data32 got=%h exp=0", obs32); else n_pass++;
    n_total++; if (obs64 !== '0) $display("FAIL reset_data64 got=%h exp=0", obs64); else n_pass++;
  endtask

  task automatic test_decode();
    logic [31:0] vec [20];
    logic [31:0] pc;
    int          lat;
    bit          seen;
    vec[0] = 32'hFFF10093; vec[1] = 32'h00112223; vec[2] = 32'hFE000EE3;
    vec[3] = 32'h123452B7; vec[4] = 32'h800002B7; vec[5] = 32'h00000013;
    vec[6] = 32'h00000000; vec[7] = 32'h00208033;
    for (int k = 8; k < 20; k++) vec[k] = rand_instr(k);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      pc = 32'h100 + 32'(k) * 4;
      in_valid = 1'b1; in_instr = vec[k]; in_pc = pc; out_ready = 1'b1;
      #1;
      n_total++; if (a_in_ready !== 1'b1) $display("FAIL dec_in_ready k=%0d got=%b exp=1", k, a_in_ready); else n_pass++;
      if (a_in_ready) exp_q.push_back(model(vec[k], pc));
      lat = 0; seen = 1'b0;
      for (int w = 0; w < 5 && !seen; w++) begin
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        lat++;
        if (a_out_valid && exp_q.size() > 0) begin
          seen = 1'b1;
          n_total++; if (obs32 !== sig32(exp_q[0]))
            $display("FAIL dec_out32 instr=%h got=%h exp=%h", vec[k], obs32, sig32(exp_q[0])); else n_pass++;
          n_total++; if (obs64 !== sig64(exp_q[0]))
            $display("FAIL dec_out64 instr=%h got=%h exp=%h", vec[k], obs64, sig64(exp_q[0])); else n_pass++;
          void'(exp_q.pop_front());
        end
      end
      n_total++; if (!seen || lat != 1) $display("FAIL dec_latency instr=%h got=%0d exp=1", vec[k], seen ? lat : -1); else n_pass++;
      if (vec[k] == 32'hFFF10093) begin
        n_total++; if (a_imm !== 32'hFFFFFFFF || a_rd !== 5'd1 || a_rs1 !== 5'd2 || a_it !== 3'd1)
          $display("FAIL addi_const got imm=%h rd=%0d rs1=%0d it=%0d exp imm=ffffffff rd=1 rs1=2 it=1",
                   a_imm, a_rd, a_rs1, a_it); else n_pass++;
      end
      if (vec[k] == 32'hFE000EE3) begin
        n_total++; if (a_imm !== 32'hFFFFFFFC || a_it !== 3'd3)
          $display("FAIL beq_const got imm=%h it=%0d exp imm=fffffffc it=3", a_imm, a_it); else n_pass++;
      end
      if (vec[k] == 32'h800002B7) begin
        n_total++; if (b_imm !== 64'hFFFFFFFF80000000)
          $display("FAIL lui64_const got=%h exp=ffffffff80000000", b_imm); else n_pass++;
      end
      if (vec[k] == 32'h00000000) begin
        n_total++; if (a_ill !== 1'b1 || a_imm !== '0 || a_imm_valid !== 1'b0)
          $display("FAIL illegal_const got ill=%b imm=%h iv=%b exp ill=1 imm=0 iv=0", a_ill, a_imm, a_imm_valid); else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] instrs [8];
    logic [31:0] pc;
    int          sent, got, stall_acc;
    bit          stall;
    sent = 0; got = 0; stall_acc = 0;
    for (int k = 0; k < 8; k++) instrs[k] = rand_instr(k * 5 + 1);
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      stall     = (c >= 3 && c <= 5);
      pc        = 32'h2000 + 32'(sent) * 4;
      out_ready = !stall;
      in_valid  = (sent < 8);
      in_instr  = (sent < 8) ? instrs[sent] : '0;
      in_pc     = pc;
      #1;
      if (a_out_valid) begin
        n_total++;
        if (exp_q.size() == 0) $display("FAIL b2b_extra got=%h exp=none", obs32);
        else if (obs32 !== sig32(exp_q[0]) || obs64 !== sig64(exp_q[0]))
          $display("FAIL b2b_out cycle=%0d got=%h exp=%h", c, obs32, sig32(exp_q[0]));
        else n_pass++;
        if (out_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          got++;
        end
      end
      if (in_valid && a_in_ready) begin
        exp_q.push_back(model(in_instr, pc));
        sent++;
        if (stall) stall_acc++;
      end
    end
    n_total++; if (got != 8) $display("FAIL b2b_count got=%0d exp=8", got); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL b2b_leftover got=%0d exp=0", exp_q.size()); else n_pass++;
    n_total++; if (stall_acc != EXP_STALL_ACC)
      $display("FAIL b2b_stall_accepts got=%0d exp=%0d", stall_acc, EXP_STALL_ACC); else n_pass++;
  endtask

  task automatic test_flush();
    logic [31:0] d_instr;
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00500113; in_pc = 32'h3000; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    in_instr = 32'h00600193; in_pc = 32'h3004;
    #1;
    n_total++; if (a_out_valid !== 1'b1) $display("FAIL flush_setup got=%b exp=1", a_out_valid); else n_pass++;
    @(negedge clk);
    flush = 1'b1; in_instr = 32'h00700213; in_pc = 32'h3008;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    #1;
    n_total++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0)
      $display("FAIL flush_out_valid got=%b/%b exp=0/0", a_out_valid, b_out_valid); else n_pass++;
    n_total++; if (a_in_ready !== 1'b1) $display("FAIL flush_in_ready got=%b exp=1", a_in_ready); else n_pass++;
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL flush_stale got=%b exp=0", a_out_valid); else n_pass++;
    @(negedge clk);
    d_instr = 32'h00C0006F;
    in_valid = 1'b1; in_instr = d_instr; in_pc = 32'h3100;
    #1;
    if (a_in_ready) exp_q.push_back(model(d_instr, 32'h3100));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_total++;
    if (!a_out_valid || exp_q.size() == 0) $display("FAIL flush_next_valid got=%b exp=1", a_out_valid);
    else if (obs32 !== sig32(exp_q[0]) || obs64 !== sig64(exp_q[0]))
      $display("FAIL flush_next_data got=%h exp=%h", obs32, sig32(exp_q[0]));
    else n_pass++;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
    #1;
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL flush_drained got=%b exp=0", a_out_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
